// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: round-robin arbiter with a one-hot FSM, hold timeout and illegal-state recovery.
// Defining ARB_ERR_CNT_EN adds a saturating err_count output.
module onehot_rr_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT = 15,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic [3:0]   state,
  output logic         timeout_err,
  output logic         illegal_err
`ifdef ARB_ERR_CNT_EN
  ,
  output logic [7:0]   err_count
`endif
);
  localparam int PW = $clog2(N);
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    ARB     = 4'b0010,
    GRANT   = 4'b0100,
    RECOVER = 4'b1000
  } state_e;
  logic [3:0]    nxt;
  logic [PW-1:0] ptr, nxt_ptr, owner, nxt_owner, pick, idx, ptr_inc;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          t_err, i_err;
  assign busy = (state == GRANT);
  assign ptr_inc = (owner == PW'(N-1)) ? '0 : owner + 1'b1;
  // descending scan so the requester closest to ptr is written last and wins
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = N-1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) pick = idx;
    end
  end
  always_comb begin
    nxt = IDLE;
    nxt_ptr = ptr;
    nxt_owner = owner;
    nxt_cnt = cnt;
    t_err = 1'b0;
    i_err = 1'b0;
    case (state)
      IDLE: nxt = |req ? ARB : IDLE;
      ARB: begin
        nxt = |req ? GRANT : IDLE;
        nxt_owner = |req ? pick : owner;
        nxt_cnt = '0;
      end
      GRANT: begin
        if (!req[owner]) nxt_ptr = ptr_inc;
        else if (cnt == CW'(TIMEOUT-1)) begin
          nxt = RECOVER;
          t_err = 1'b1;
          nxt_ptr = ptr_inc;
        end else begin
          nxt = GRANT;
          nxt_cnt = cnt + 1'b1;
        end
      end
      RECOVER: nxt = IDLE;
      default: i_err = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      timeout_err <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      state <= nxt;
      gnt <= (nxt == GRANT) ? N'(1) << nxt_owner : '0;
      ptr <= nxt_ptr;
      owner <= nxt_owner;
      cnt <= nxt_cnt;
      timeout_err <= t_err;
      illegal_err <= i_err;
    end
  end
`ifdef ARB_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) err_count <= '0;
    else if ((timeout_err || illegal_err) && !(&err_count)) err_count <= err_count + 1'b1;
  end
`endif
endmodule
